// File: rtl/pll_reconfig_pkg.sv
// Register map, counter/preset types and stored PLL presets for the
// Cyclone V fractional PLL reconfiguration master.
package pll_reconfig_pkg;

    localparam logic [5:0] REG_MODE   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_START  = 6'h02;
    localparam logic [5:0] REG_N      = 6'h03;
    localparam logic [5:0] REG_M      = 6'h04;
    localparam logic [5:0] REG_C      = 6'h05;
    localparam logic [5:0] REG_K      = 6'h07;

    typedef struct packed {
        logic       odd;
        logic       bypass;
        logic [7:0] hi;
        logic [7:0] lo;
    } cnt_t;

    typedef struct packed {
        cnt_t             n;
        cnt_t             m;
        cnt_t [17:0]      c;
        logic [31:0]      k;
    } preset_t;

    function automatic cnt_t cnt(
        input logic       odd,
        input logic       byp,
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        cnt_t r;
        r.odd    = odd;
        r.bypass = byp;
        r.hi     = hi;
        r.lo     = lo;
        return r;
    endfunction

    // C0 carries the video clock; the remaining C counters share one setting.
    function automatic preset_t mk_preset(
        input cnt_t        n,
        input cnt_t        m,
        input cnt_t        c0,
        input cnt_t        cx,
        input logic [31:0] k
    );
        preset_t p;
        p.n = n;
        p.m = m;
        p.k = k;
        for (int i = 0; i < 18; i++) begin
            p.c[i] = (i == 0) ? c0 : cx;
        end
        return p;
    endfunction

    localparam preset_t PLL_PRESETS [8] = '{
        mk_preset(cnt(1'b0, 1'b1, 8'd0, 8'd0),
                  cnt(1'b0, 1'b0, 8'd4, 8'd4),
                  cnt(1'b1, 1'b0, 8'd5, 8'd4),
                  cnt(1'b0, 1'b0, 8'd5, 8'd5),
                  32'd3274482981),
        mk_preset(cnt(1'b0, 1'b0, 8'd2, 8'd2),
                  cnt(1'b1, 1'b0, 8'd9, 8'd8),
                  cnt(1'b0, 1'b0, 8'd6, 8'd6),
                  cnt(1'b0, 1'b0, 8'd6, 8'd6),
                  32'h4CCC_CCCD),
        mk_preset(cnt(1'b0, 1'b1, 8'd0, 8'd0),
                  cnt(1'b0, 1'b0, 8'd5, 8'd5),
                  cnt(1'b0, 1'b0, 8'd7, 8'd7),
                  cnt(1'b0, 1'b0, 8'd7, 8'd7),
                  32'h2000_0000),
        mk_preset(cnt(1'b0, 1'b1, 8'd0, 8'd0),
                  cnt(1'b1, 1'b0, 8'd5, 8'd4),
                  cnt(1'b1, 1'b0, 8'd6, 8'd5),
                  cnt(1'b0, 1'b0, 8'd6, 8'd6),
                  32'h8F5C_28F6),
        mk_preset(cnt(1'b0, 1'b0, 8'd1, 8'd1),
                  cnt(1'b0, 1'b0, 8'd6, 8'd6),
                  cnt(1'b0, 1'b0, 8'd8, 8'd8),
                  cnt(1'b0, 1'b0, 8'd8, 8'd8),
                  32'h1999_999A),
        mk_preset(cnt(1'b0, 1'b1, 8'd0, 8'd0),
                  cnt(1'b0, 1'b0, 8'd4, 8'd4),
                  cnt(1'b1, 1'b0, 8'd4, 8'd3),
                  cnt(1'b0, 1'b0, 8'd4, 8'd4),
                  32'hB851_EB85),
        mk_preset(cnt(1'b0, 1'b1, 8'd0, 8'd0),
                  cnt(1'b0, 1'b0, 8'd3, 8'd3),
                  cnt(1'b0, 1'b0, 8'd3, 8'd3),
                  cnt(1'b0, 1'b0, 8'd3, 8'd3),
                  32'h6666_6666),
        mk_preset(cnt(1'b0, 1'b0, 8'd2, 8'd2),
                  cnt(1'b1, 1'b0, 8'd8, 8'd7),
                  cnt(1'b0, 1'b1, 8'd0, 8'd0),
                  cnt(1'b0, 1'b0, 8'd9, 8'd9),
                  32'h0000_0000)
    };

    function automatic logic [31:0] enc_cnt(input cnt_t c, input logic [4:0] idx);
        return {9'd0, idx, c.odd, c.bypass, c.hi, c.lo};
    endfunction

endpackage

// File: rtl/pll_mgmt_writer.sv
// Single Avalon-MM write master: holds write/address/data stable until
// the reconfig IP drops waitrequest, then deasserts write for a cycle.
module pll_mgmt_writer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_go,
    input  logic [5:0]  i_addr,
    input  logic [31:0] i_data,
    input  logic        i_waitrequest,
    output logic        o_mgmt_write,
    output logic [5:0]  o_mgmt_address,
    output logic [31:0] o_mgmt_writedata,
    output logic        o_ack
);

    logic        r_write;
    logic [5:0]  r_addr;
    logic [31:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (r_write) begin
            if (!i_waitrequest) begin
                r_write <= 1'b0;
            end
        end else if (i_go) begin
            r_write <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end
    end

    // Ack in the completing cycle lets the caller advance without a bubble.
    assign o_ack            = r_write & ~i_waitrequest;
    assign o_mgmt_write     = r_write;
    assign o_mgmt_address   = r_addr;
    assign o_mgmt_writedata = r_data;

endmodule

// File: rtl/pll_preset_switcher.sv
// Switches a Cyclone V fractional PLL between stored presets through the
// reconfig mgmt port, then waits for the PLL to unlock and relock.
module pll_preset_switcher
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_PRESETS  = 2,
    parameter int NUM_CLOCKS   = 1,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [2:0]  i_sel,
    input  logic        i_force,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_active_sel,
    output logic [5:0]  o_mgmt_address,
    output logic        o_mgmt_write,
    output logic [31:0] o_mgmt_writedata,
    input  logic        i_mgmt_waitrequest,
    input  logic        i_pll_locked
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_MODE   = 4'd1;
    localparam logic [3:0] S_N      = 4'd2;
    localparam logic [3:0] S_M      = 4'd3;
    localparam logic [3:0] S_C      = 4'd4;
    localparam logic [3:0] S_K      = 4'd5;
    localparam logic [3:0] S_START  = 4'd6;
    localparam logic [3:0] S_UNLOCK = 4'd7;
    localparam logic [3:0] S_LOCK   = 4'd8;

    localparam int         TMO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0] NP       = 4'(NUM_PRESETS);
    localparam logic [4:0] LAST_C   = 5'(NUM_CLOCKS - 1);

    logic [3:0]       r_state;
    logic [2:0]       r_sel;
    logic [2:0]       r_active;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [4:0]       r_cidx;
    logic [TMO_W-1:0] r_tmo;
    logic [3:0]       r_lockcnt;
    logic             r_lock_meta;
    logic             r_lock_s;

    logic             w_wr_state;
    logic             w_go;
    logic [5:0]       w_addr;
    logic [31:0]      w_data;
    logic             w_ack;
    logic             w_wr_active;
    logic             w_tmo_hit;
    logic             w_locked_ok;
    preset_t          w_preset;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= i_pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_preset = PLL_PRESETS[r_sel];

    always_comb begin
        w_wr_state = 1'b1;
        w_addr     = REG_MODE;
        w_data     = 32'd0;
        case (r_state)
            S_MODE:  begin
                w_addr = REG_MODE;
                w_data = 32'd0;
            end
            S_N:     begin
                w_addr = REG_N;
                w_data = enc_cnt(w_preset.n, 5'd0);
            end
            S_M:     begin
                w_addr = REG_M;
                w_data = enc_cnt(w_preset.m, 5'd0);
            end
            S_C:     begin
                w_addr = REG_C;
                w_data = enc_cnt(w_preset.c[r_cidx], r_cidx);
            end
            S_K:     begin
                w_addr = REG_K;
                w_data = w_preset.k;
            end
            S_START: begin
                w_addr = REG_START;
                w_data = 32'd1;
            end
            default: w_wr_state = 1'b0;
        endcase
    end

    // A new write is only launched once the previous strobe has dropped.
    assign w_go        = w_wr_state & ~w_wr_active;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_locked_ok = r_lock_s && (r_lockcnt == 4'd15);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_active  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cidx    <= '0;
            r_tmo     <= '0;
            r_lockcnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req && !r_done) begin
                        r_sel  <= i_sel;
                        r_err  <= 1'b0;
                        r_cidx <= '0;
                        if ({1'b0, i_sel} >= NP) begin
                            r_err <= 1'b1;
                        end else if (i_sel == r_active && !i_force) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_MODE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_MODE:  if (w_ack) r_state <= S_N;
                S_N:     if (w_ack) r_state <= S_M;
                S_M:     if (w_ack) r_state <= S_C;
                S_C: begin
                    if (w_ack) begin
                        if (r_cidx == LAST_C) begin
                            r_state <= S_K;
                        end else begin
                            r_cidx <= r_cidx + 5'd1;
                        end
                    end
                end
                S_K:     if (w_ack) r_state <= S_START;
                S_START: begin
                    if (w_ack) begin
                        r_state   <= S_UNLOCK;
                        r_tmo     <= '0;
                        r_lockcnt <= '0;
                    end
                end
                S_UNLOCK, S_LOCK: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (r_state == S_UNLOCK) begin
                        if (!r_lock_s) r_state <= S_LOCK;
                    end else if (r_lock_s) begin
                        r_lockcnt <= r_lockcnt + 4'd1;
                    end else begin
                        r_lockcnt <= '0;
                    end
                    if (r_state == S_LOCK && w_locked_ok) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_active <= r_sel;
                    end else if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    pll_mgmt_writer u_writer (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_go             (w_go),
        .i_addr           (w_addr),
        .i_data           (w_data),
        .i_waitrequest    (i_mgmt_waitrequest),
        .o_mgmt_write     (w_wr_active),
        .o_mgmt_address   (o_mgmt_address),
        .o_mgmt_writedata (o_mgmt_writedata),
        .o_ack            (w_ack)
    );

    assign o_mgmt_write = w_wr_active;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_active_sel = r_active;

endmodule

// File: tb/tb_pll_preset_switcher.sv
// Directed bench for pll_preset_switcher with a reconfig IP / PLL lock model.
module tb_pll_preset_switcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [2:0]  sel;
    logic        frc;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  active_sel;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        waitrequest = 1'b0;
    logic        pll_locked;

    int total = 0;
    int bad   = 0;

    logic [5:0]  wa[$];
    logic [31:0] wd[$];
    int          done_cnt = 0;
    int          stab_err = 0;
    int          cyc      = 0;
    int          start_t  = 0;
    int          lk_cnt   = 0;
    bit          lock_dead = 1'b0;
    int          wr_mode  = 0;
    bit          stalled  = 1'b0;
    logic [5:0]  s_a;
    logic [31:0] s_d;
    bit          in_wr    = 1'b0;
    int          st       = 0;

    always #5 clk = ~clk;

    pll_preset_switcher #(
        .NUM_PRESETS  (2),
        .NUM_CLOCKS   (1),
        .LOCK_TIMEOUT (100)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req              (req),
        .i_sel              (sel),
        .i_force            (frc),
        .o_busy             (busy),
        .o_done             (done),
        .o_err              (err),
        .o_active_sel       (active_sel),
        .o_mgmt_address     (mgmt_address),
        .o_mgmt_write       (mgmt_write),
        .o_mgmt_writedata   (mgmt_writedata),
        .i_mgmt_waitrequest (waitrequest),
        .i_pll_locked       (pll_locked)
    );

    assign pll_locked = !(lk_cnt >= 3 && (lock_dead || lk_cnt < 12));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lk_cnt != 0 && lk_cnt < 40) lk_cnt <= lk_cnt + 1;
        if (!rst_n) begin
            stalled <= 1'b0;
        end else begin
            if (mgmt_write && !waitrequest) begin
                wa.push_back(mgmt_address);
                wd.push_back(mgmt_writedata);
                if (mgmt_address == 6'h02) begin
                    lk_cnt  <= 1;
                    start_t <= cyc;
                end
            end
            if (stalled && !(mgmt_write && mgmt_address == s_a
                             && mgmt_writedata == s_d))
                stab_err <= stab_err + 1;
            stalled <= mgmt_write && waitrequest;
            s_a     <= mgmt_address;
            s_d     <= mgmt_writedata;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (wr_mode == 2) begin
            waitrequest = mgmt_write && (mgmt_address == 6'h04);
        end else if (mgmt_write) begin
            if (!in_wr) begin
                in_wr = 1'b1;
                st = (wr_mode == 1) ? int'($urandom_range(0, 7)) : 0;
            end
            waitrequest = (st != 0);
            if (st != 0) st--;
        end else begin
            in_wr = 1'b0;
            waitrequest = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [2:0] s, input logic f);
        @(negedge clk);
        req = 1'b1;
        sel = s;
        frc = f;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag, input logic [31:0] dn,
                                input logic [31:0] dm, input logic [31:0] dc,
                                input logic [31:0] dk);
        logic [5:0]  ea[6];
        logic [31:0] ed[6];
        ea = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h07, 6'h02};
        ed = '{32'd0, dn, dm, dc, dk, 32'd1};
        chk({tag, "_nwr"}, wa.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wa.size()) begin
                chk($sformatf("%s_a%0d", tag, i), {26'd0, wa[i]}, {26'd0, ea[i]});
                chk($sformatf("%s_d%0d", tag, i), wd[i], ed[i]);
            end
        end
    endtask

    initial begin
        bit ok;
        int d0;
        int t_err;

        rst_n = 1'b0;
        req   = 1'b0;
        sel   = 3'd0;
        frc   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_act", active_sel, 0);
        chk("rst_wr", mgmt_write, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_data", mgmt_writedata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Same preset as booted, no force: immediate done, no writes.
        do_req(3'd0, 1'b0);
        chk("skip_done", done, 1);
        chk("skip_busy", busy, 0);
        @(negedge clk);
        chk("skip_done_off", done, 0);
        chk("skip_nwr", wa.size(), 0);

        // Full switch to preset 1, no stalls.
        wa.delete(); wd.delete();
        d0 = done_cnt;
        do_req(3'd1, 1'b0);
        chk("s1_busy", busy, 1);
        wait_done(400, ok);
        chk("s1_done_seen", ok, 1);
        chk("s1_busy_off", busy, 0);
        chk("s1_act", active_sel, 1);
        repeat (5) @(negedge clk);
        chk("s1_done_once", done_cnt - d0, 1);
        chk("s1_err", err, 0);
        check_writes("s1", 32'h0000_0202, 32'h0002_0908, 32'h0000_0606,
                     32'h4CCC_CCCD);

        // Forced reprogram of preset 1 under random waitrequest stalls.
        wr_mode = 1;
        wa.delete(); wd.delete();
        d0 = done_cnt;
        do_req(3'd1, 1'b1);
        wait_done(1500, ok);
        chk("s2_done_seen", ok, 1);
        repeat (5) @(negedge clk);
        chk("s2_done_once", done_cnt - d0, 1);
        chk("s2_stable", stab_err, 0);
        chk("s2_act", active_sel, 1);
        check_writes("s2", 32'h0000_0202, 32'h0002_0908, 32'h0000_0606,
                     32'h4CCC_CCCD);
        wr_mode = 0;

        // Back to preset 0, then force-reprogram it.
        wa.delete(); wd.delete();
        do_req(3'd0, 1'b0);
        wait_done(400, ok);
        chk("p0_done_seen", ok, 1);
        chk("p0_act", active_sel, 0);
        check_writes("p0", 32'h0001_0000, 32'h0000_0404, 32'h0002_0504,
                     32'hC32C_A525);
        wa.delete(); wd.delete();
        do_req(3'd0, 1'b1);
        wait_done(400, ok);
        chk("frc_done_seen", ok, 1);
        chk("frc_nwr", wa.size(), 6);

        // Out-of-range preset.
        repeat (2) @(negedge clk);
        wa.delete(); wd.delete();
        d0 = done_cnt;
        do_req(3'd7, 1'b0);
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("bad_nwr", wa.size(), 0);
        chk("bad_nodone", done_cnt - d0, 0);

        // Requests while busy are dropped.
        d0 = done_cnt;
        do_req(3'd1, 1'b0);
        chk("busy_err_clr", err, 0);
        chk("busy_on", busy, 1);
        repeat (3) @(negedge clk);
        do_req(3'd0, 1'b1);
        wait_done(400, ok);
        chk("busy_done_seen", ok, 1);
        repeat (20) @(negedge clk);
        chk("busy_act", active_sel, 1);
        chk("busy_nwr", wa.size(), 6);
        chk("busy_done_once", done_cnt - d0, 1);

        // Lock never returns: timeout about LOCK_TIMEOUT cycles after START.
        lock_dead = 1'b1;
        d0 = done_cnt;
        do_req(3'd0, 1'b0);
        ok = 1'b0;
        t_err = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (err) begin
                ok = 1'b1;
                t_err = cyc;
                break;
            end
        end
        chk("to_err", ok, 1);
        chk("to_busy", busy, 0);
        chk("to_act", active_sel, 1);
        chk("to_nodone", done_cnt - d0, 0);
        chk("to_delay", (t_err - start_t >= 99) && (t_err - start_t <= 103), 1);
        lock_dead = 1'b0;
        repeat (4) @(negedge clk);
        do_req(3'd1, 1'b0);
        chk("to_err_clr", err, 0);
        chk("to_skip_done", done, 1);

        // Reset during a stalled M write.
        wr_mode = 2;
        do_req(3'd0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == 6'h04) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rs_mstall", ok, 1);
        repeat (3) @(negedge clk);
        chk("rs_held", mgmt_write, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_wr", mgmt_write, 0);
        chk("rs_busy", busy, 0);
        chk("rs_act", active_sel, 0);
        chk("rs_err", err, 0);
        chk("rs_done", done, 0);
        chk("rs_addr", mgmt_address, 0);
        chk("rs_data", mgmt_writedata, 0);
        wr_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
